// File: rtl/nano_rv32i_pkg.sv
// Shared definitions for the nano_rv32i MMIO peripherals:
// GPIO register word offsets and AXI-Lite slave FSM state encodings.
package nano_rv32i_pkg;

    localparam logic [2:0] GPIO_OFF_DATA_OUT   = 3'd0;
    localparam logic [2:0] GPIO_OFF_DATA_IN    = 3'd1;
    localparam logic [2:0] GPIO_OFF_DIR        = 3'd2;
    localparam logic [2:0] GPIO_OFF_SET        = 3'd3;
    localparam logic [2:0] GPIO_OFF_CLR        = 3'd4;
    localparam logic [2:0] GPIO_OFF_IRQ_EN     = 3'd5;
    localparam logic [2:0] GPIO_OFF_IRQ_STATUS = 3'd6;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } gpio_wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } gpio_rstate_e;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for asynchronous pad inputs.
// Both stages reset to zero.
module gpio_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops to settle metastability.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/axi_lite_gpio.sv
// AXI-Lite slave GPIO: DATA_OUT, DATA_IN, DIR, SET/CLR aliases.
// Define GPIO_IRQ_EN to add IRQ_EN / IRQ_STATUS registers and irq_o.
module axi_lite_gpio
    import nano_rv32i_pkg::*;
#(
    parameter int          GPIO_WIDTH = 8,
    parameter logic [31:0] RESET_OUT  = 32'h0,
    parameter int          ADDR_LSB   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [31:0]           s_axi_awaddr_i,
    input  logic                  s_axi_awvalid_i,
    output logic                  s_axi_awready_o,
    input  logic [31:0]           s_axi_wdata_i,
    input  logic                  s_axi_wvalid_i,
    output logic                  s_axi_wready_o,
    output logic                  s_axi_bvalid_o,
    input  logic [31:0]           s_axi_araddr_i,
    input  logic                  s_axi_arvalid_i,
    output logic                  s_axi_arready_o,
    output logic [31:0]           s_axi_rdata_o,
    output logic                  s_axi_rvalid_o,
    input  logic                  s_axi_rready_i,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe_o
`ifdef GPIO_IRQ_EN
    ,
    output logic                  irq_o
`endif
);

    gpio_wstate_e          wstate_q, wstate_d;
    gpio_rstate_e          rstate_q, rstate_d;
    logic                  aw_done_q, w_done_q;
    logic [2:0]            awoff_q;
    logic [GPIO_WIDTH-1:0] wdata_q;
    logic [GPIO_WIDTH-1:0] data_out_q, dir_q, din;
    logic [31:0]           rdata_q, rd_val;
    logic                  aw_hs, w_hs, wr_fire, ar_hs;
    logic [2:0]            wr_off, rd_off;
    logic [GPIO_WIDTH-1:0] wr_data;
    logic                  unused_bits;

    assign unused_bits = ^{s_axi_awaddr_i, s_axi_araddr_i, s_axi_wdata_i};

    gpio_sync #(.WIDTH(GPIO_WIDTH)) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (gpio_i),
        .q_o     (din)
    );

    assign aw_hs   = (wstate_q == W_IDLE) && !aw_done_q && s_axi_awvalid_i;
    assign w_hs    = (wstate_q == W_IDLE) && !w_done_q && s_axi_wvalid_i;
    assign wr_fire = (wstate_q == W_IDLE)
                   && (aw_done_q || s_axi_awvalid_i)
                   && (w_done_q || s_axi_wvalid_i);
    assign wr_off  = aw_done_q ? awoff_q : s_axi_awaddr_i[ADDR_LSB+2:ADDR_LSB];
    assign wr_data = w_done_q ? wdata_q : s_axi_wdata_i[GPIO_WIDTH-1:0];

    // Write FSM next state and channel handshake outputs.
    always_comb begin
        wstate_d        = wstate_q;
        s_axi_awready_o = 1'b0;
        s_axi_wready_o  = 1'b0;
        s_axi_bvalid_o  = 1'b0;
        unique case (wstate_q)
            W_IDLE: begin
                s_axi_awready_o = !aw_done_q;
                s_axi_wready_o  = !w_done_q;
                if (wr_fire) wstate_d = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid_o = 1'b1;
                wstate_d       = W_IDLE;
            end
        endcase
    end

    // Write FSM state and capture of whichever half arrives first.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wstate_q  <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awoff_q   <= '0;
            wdata_q   <= '0;
        end else begin
            wstate_q <= wstate_d;
            if (wr_fire) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_done_q <= 1'b1;
                    awoff_q   <= s_axi_awaddr_i[ADDR_LSB+2:ADDR_LSB];
                end
                if (w_hs) begin
                    w_done_q <= 1'b1;
                    wdata_q  <= s_axi_wdata_i[GPIO_WIDTH-1:0];
                end
            end
        end
    end

    // Output data and direction registers, updated on write completion.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_out_q <= RESET_OUT[GPIO_WIDTH-1:0];
            dir_q      <= '0;
        end else if (wr_fire) begin
            case (wr_off)
                GPIO_OFF_DATA_OUT: data_out_q <= wr_data;
                GPIO_OFF_DIR:      dir_q      <= wr_data;
                GPIO_OFF_SET:      data_out_q <= data_out_q | wr_data;
                GPIO_OFF_CLR:      data_out_q <= data_out_q & ~wr_data;
                default:           ;
            endcase
        end
    end

    assign gpio_o    = data_out_q;
    assign gpio_oe_o = dir_q;

`ifdef GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] irq_en_q, irq_status_q, din_prev_q;
    logic [GPIO_WIDTH-1:0] irq_rise, irq_clr;
    logic                  irq_q;

    assign irq_rise = din & ~din_prev_q & irq_en_q & ~dir_q;
    assign irq_clr  = (wr_fire && wr_off == GPIO_OFF_IRQ_STATUS) ? wr_data : '0;

    // Input edge detect; a new edge beats a same-cycle W1C.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            irq_en_q     <= '0;
            irq_status_q <= '0;
            din_prev_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            din_prev_q   <= din;
            irq_status_q <= (irq_status_q & ~irq_clr) | irq_rise;
            irq_q        <= |irq_status_q;
            if (wr_fire && wr_off == GPIO_OFF_IRQ_EN) irq_en_q <= wr_data;
        end
    end

    assign irq_o = irq_q;
`endif

    assign rd_off = s_axi_araddr_i[ADDR_LSB+2:ADDR_LSB];
    assign ar_hs  = (rstate_q == R_IDLE) && s_axi_arvalid_i;

    // Read data mux, zero-extended to the bus width.
    always_comb begin
        rd_val = '0;
        case (rd_off)
            GPIO_OFF_DATA_OUT:   rd_val = 32'(data_out_q);
            GPIO_OFF_DATA_IN:    rd_val = 32'(din);
            GPIO_OFF_DIR:        rd_val = 32'(dir_q);
`ifdef GPIO_IRQ_EN
            GPIO_OFF_IRQ_EN:     rd_val = 32'(irq_en_q);
            GPIO_OFF_IRQ_STATUS: rd_val = 32'(irq_status_q);
`endif
            default:             rd_val = '0;
        endcase
    end

    // Read FSM next state and channel outputs.
    always_comb begin
        rstate_d        = rstate_q;
        s_axi_arready_o = 1'b0;
        s_axi_rvalid_o  = 1'b0;
        unique case (rstate_q)
            R_IDLE: begin
                s_axi_arready_o = 1'b1;
                if (s_axi_arvalid_i) rstate_d = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid_o = 1'b1;
                if (s_axi_rready_i) rstate_d = R_IDLE;
            end
        endcase
    end

    // Read FSM state and read data held until accepted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rstate_q <= R_IDLE;
            rdata_q  <= '0;
        end else begin
            rstate_q <= rstate_d;
            if (ar_hs) rdata_q <= rd_val;
        end
    end

    assign s_axi_rdata_o = rdata_q;

endmodule

// File: tb/tb_axi_lite_gpio.sv
// Self-checking bench for axi_lite_gpio against a register-level model.
// Build with GPIO_IRQ_EN defined to also exercise the interrupt block.
module tb_axi_lite_gpio;

    localparam int W = 8;
    localparam logic [7:0] RST_OUT = 8'hA5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   awaddr = '0, wdata = '0, araddr = '0;
    logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [31:0]   rdata;
    logic [W-1:0]  gpio_in = '0;
    logic [W-1:0]  gpio_out, gpio_oe;
`ifdef GPIO_IRQ_EN
    logic          irq;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_out = RST_OUT;
    logic [W-1:0] m_dir = '0;
    logic [W-1:0] m_en = '0;
    logic [W-1:0] m_stat = '0;

    always #5 clk = ~clk;

    axi_lite_gpio #(
        .GPIO_WIDTH (W),
        .RESET_OUT  (32'(RST_OUT)),
        .ADDR_LSB   (2)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .s_axi_awaddr_i  (awaddr),
        .s_axi_awvalid_i (awvalid),
        .s_axi_awready_o (awready),
        .s_axi_wdata_i   (wdata),
        .s_axi_wvalid_i  (wvalid),
        .s_axi_wready_o  (wready),
        .s_axi_bvalid_o  (bvalid),
        .s_axi_araddr_i  (araddr),
        .s_axi_arvalid_i (arvalid),
        .s_axi_arready_o (arready),
        .s_axi_rdata_o   (rdata),
        .s_axi_rvalid_o  (rvalid),
        .s_axi_rready_i  (rready),
        .gpio_i          (gpio_in),
        .gpio_o          (gpio_out),
        .gpio_oe_o       (gpio_oe)
`ifdef GPIO_IRQ_EN
        ,
        .irq_o           (irq)
`endif
    );

    function automatic void model_reset();
        m_out  = RST_OUT;
        m_dir  = '0;
        m_en   = '0;
        m_stat = '0;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
        int idx = int'((a >> 2) & 32'h7);
        logic [W-1:0] v = d[W-1:0];
        if (idx == 0) m_out = v;
        else if (idx == 2) m_dir = v;
        else if (idx == 3) m_out = m_out | v;
        else if (idx == 4) m_out = m_out & ~v;
`ifdef GPIO_IRQ_EN
        else if (idx == 5) m_en = v;
        else if (idx == 6) m_stat = m_stat & ~v;
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int idx = int'((a >> 2) & 32'h7);
        logic [W-1:0] v = '0;
        if (idx == 0) v = m_out;
        else if (idx == 1) v = gpio_in;
        else if (idx == 2) v = m_dir;
`ifdef GPIO_IRQ_EN
        else if (idx == 5) v = m_en;
        else if (idx == 6) v = m_stat;
`endif
        return {24'h0, v};
    endfunction

    task automatic set_gpio(input logic [W-1:0] v);
        m_stat  = m_stat | (v & ~gpio_in & m_en & ~m_dir);
        gpio_in = v;
        repeat (3) @(negedge clk);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input int aw_dly, input int w_dly);
        bit aw_ok = 0;
        bit w_ok = 0;
        int c = 0;
        while (!(aw_ok && w_ok) && c < 64) begin
            @(negedge clk);
            checks++;
            if (bvalid !== 1'b0) begin
                errors++;
                $display("FAIL wr_bvalid_early: got %b want 0", bvalid);
            end
            if (aw_ok) begin
                checks++;
                if (awready !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_awready_held: got %b want 0", awready);
                end
            end
            if (w_ok) begin
                checks++;
                if (wready !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_wready_held: got %b want 0", wready);
                end
            end
            awaddr  = a;
            wdata   = d;
            awvalid = !aw_ok && c >= aw_dly;
            wvalid  = !w_ok && c >= w_dly;
            #1;
            if (awvalid && awready) aw_ok = 1;
            if (wvalid && wready) w_ok = 1;
            c++;
        end
        checks++;
        if (!(aw_ok && w_ok)) begin
            errors++;
            $display("FAIL wr_timeout: got aw=%b w=%b want both accepted", aw_ok, w_ok);
        end
        model_write(a, d);
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp: got b=%b aw=%b w=%b want 1 0 0",
                     bvalid, awready, wready);
        end
        checks++;
        if (gpio_out !== m_out || gpio_oe !== m_dir) begin
            errors++;
            $display("FAIL wr_regs a=%h: got out=%h oe=%h want %h %h",
                     a, gpio_out, gpio_oe, m_out, m_dir);
        end
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            errors++;
            $display("FAIL wr_idle: got b=%b aw=%b w=%b want 0 1 1",
                     bvalid, awready, wready);
        end
    endtask

    task automatic axi_read(input logic [31:0] a, input int stall);
        logic [31:0] exp;
        int c = 0;
        @(negedge clk);
        rready  = 1'b0;
        araddr  = a;
        arvalid = 1'b1;
        #1;
        while (arready !== 1'b1 && c < 16) begin
            @(negedge clk);
            #1;
            c++;
        end
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL rd_arready: got %b want 1", arready);
        end
        exp = model_read(a);
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (rvalid !== 1'b1 || rdata !== exp || arready !== 1'b0) begin
                errors++;
                $display("FAIL rd_data a=%h cyc=%0d: got v=%b d=%h ar=%b want 1 %h 0",
                         a, i, rvalid, rdata, arready, exp);
            end
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++;
            $display("FAIL rd_done: got v=%b ar=%b want 0 1", rvalid, arready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (gpio_out !== RST_OUT || gpio_oe !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs: got out=%h oe=%h want %h 00", gpio_out, gpio_oe, RST_OUT);
        end
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_axi: got rdy=%b%b%b b=%b r=%b d=%h want 111 0 0 0",
                     awready, wready, arready, bvalid, rvalid, rdata);
        end
`ifdef GPIO_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b want 0", irq);
        end
`endif
        rst_n = 1'b1;
        model_reset();
        axi_read(32'h00, 0);
    endtask

    task automatic test_same_cycle();
        axi_write(32'h08, 32'hFF, 0, 0);
        axi_read(32'h08, 1);
    endtask

    task automatic test_skewed();
        axi_write(32'h0C, 32'h0F, 3, 0);
        checks++;
        if (gpio_out !== 8'hAF) begin
            errors++;
            $display("FAIL set_alias: got %h want AF", gpio_out);
        end
        axi_write(32'h10, 32'h01, 0, 2);
        checks++;
        if (gpio_out !== 8'hAE) begin
            errors++;
            $display("FAIL clr_alias: got %h want AE", gpio_out);
        end
    endtask

    task automatic test_read_stall();
        set_gpio(8'h3C);
        axi_read(32'h04, 4);
    endtask

    task automatic test_same_edge();
        logic [31:0] old_v = model_read(32'h00);
        logic [31:0] nv = $urandom;
        @(negedge clk);
        awaddr  = 32'h00;
        wdata   = nv;
        araddr  = 32'h00;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        arvalid = 1'b1;
        rready  = 1'b0;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        model_write(32'h00, nv);
        checks++;
        if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== old_v || gpio_out !== m_out) begin
            errors++;
            $display("FAIL same_edge: got b=%b r=%b d=%h out=%h want 1 1 %h %h",
                     bvalid, rvalid, rdata, gpio_out, old_v, m_out);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL same_edge_done: got b=%b r=%b want 0 0", bvalid, rvalid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [2:0] off = 3'($urandom_range(0, 7));
`ifdef GPIO_IRQ_EN
            if (off == 3'd5) off = 3'd0;
`endif
            a = {$urandom_range(0, 255) << 5} | {27'h0, off, 2'b00}
              | 32'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: axi_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
                1: axi_read(a, $urandom_range(0, 3));
                default: set_gpio(W'($urandom));
            endcase
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        awaddr  = 32'h00;
        araddr  = 32'h00;
        awvalid = 1'b1;
        arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        arvalid = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || gpio_out !== RST_OUT || gpio_oe !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: got b=%b r=%b out=%h oe=%h want 0 0 %h 00",
                     bvalid, rvalid, gpio_out, gpio_oe, RST_OUT);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        wdata  = 32'h55;
        wvalid = 1'b1;
        #1;
        checks++;
        if (wready !== 1'b1) begin
            errors++;
            $display("FAIL mid_wready: got %b want 1", wready);
        end
        @(negedge clk);
        wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_resp cyc=%0d: got b=%b r=%b want 0 0", i, bvalid, rvalid);
            end
            @(negedge clk);
        end
        awaddr  = 32'h1C;
        awvalid = 1'b1;
        #1;
        checks++;
        if (awready !== 1'b1) begin
            errors++;
            $display("FAIL mid_awready: got %b want 1", awready);
        end
        @(negedge clk);
        awvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || gpio_out !== RST_OUT) begin
            errors++;
            $display("FAIL mid_unmapped: got b=%b out=%h want 1 %h", bvalid, gpio_out, RST_OUT);
        end
        @(negedge clk);
        axi_read(32'h00, 0);
        axi_read(32'h08, 0);
    endtask

`ifdef GPIO_IRQ_EN
    task automatic test_irq();
        set_gpio(8'h00);
        axi_write(32'h14, 32'h03, 0, 0);
        axi_write(32'h08, 32'h02, 0, 0);
        set_gpio(8'h03);
        repeat (3) @(negedge clk);
        checks++;
        if (irq !== (m_stat != 0)) begin
            errors++;
            $display("FAIL irq_set: got %b want %b", irq, m_stat != 0);
        end
        axi_read(32'h18, 0);
        axi_write(32'h18, 32'h01, 0, 0);
        checks++;
        if (irq !== (m_stat != 0)) begin
            errors++;
            $display("FAIL irq_clr: got %b want %b", irq, m_stat != 0);
        end
        axi_read(32'h18, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_same_cycle();
        test_skewed();
        test_read_stall();
        test_same_edge();
        test_random();
        test_reset_mid();
`ifdef GPIO_IRQ_EN
        test_irq();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
